reg_file_sb: RTL
================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, register and data width in bits.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 5, register index width; register count is 2**ADDR_WIDTH.
REQ-003 SHALL provide parameter NREAD, default 2, number of independent read ports (1..4).
REQ-004 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL provide port wen  input  1  write enable.
REQ-007 SHALL provide port waddr  input  ADDR_WIDTH  write index.
REQ-008 SHALL provide port wdata  input  DATA_WIDTH  write data.
REQ-009 SHALL provide port alloc_en  input  1  marks alloc_addr as pending (producer issued).
REQ-010 SHALL provide port alloc_addr  input  ADDR_WIDTH  index to mark pending.
REQ-011 SHALL provide port raddr  input  NREAD*ADDR_WIDTH  packed read indices; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-012 SHALL provide port rdata  output  NREAD*DATA_WIDTH  packed read data, same packing.
REQ-013 SHALL provide port rbusy  output  NREAD  per-port pending flag for the addressed register.
REQ-014 SHALL provide port busy_cnt  output  ADDR_WIDTH+1  number of registers currently pending.

Function
REQ-015 SHALL hardwire register 0: reads return 0, writes ignored, allocations ignored, never pending.
REQ-016 SHALL update the addressed register with wdata on the rising clk edge when wen=1 and waddr!=0.
REQ-017 SHALL drive rdata and rbusy combinationally from raddr (zero-cycle read latency).
REQ-018 SHALL keep one pending bit per register; alloc_en=1, alloc_addr!=0 sets it on the next edge.
REQ-019 SHALL clear the pending bit of waddr on the edge where wen=1 and waddr!=0.
REQ-020 SHALL, on simultaneous alloc and write to the same non-zero index, store wdata and leave the bit set (allocation wins).
REQ-021 SHALL treat alloc of an already-pending register as a no-op on the bit; write to a non-pending register updates data, bit stays clear.
REQ-022 SHALL maintain busy_cnt as a registered count of set pending bits: +1 on set of a clear bit, -1 on clear of a set bit, unchanged when both occur or neither changes state; range 0..2**ADDR_WIDTH-1.
REQ-023 SHALL serve all NREAD ports independently, including several ports addressing the same index.

Reset
REQ-024 SHALL, on rising clk with rst=1, clear every register to 0, every pending bit to 0 and busy_cnt to 0, overriding wen and alloc_en in that cycle.
REQ-025 SHALL, in the first cycle after rst deasserts, read 0 with rbusy=0 on all ports.

Configuration
REQ-026 SHALL compile same-cycle write bypass when macro REG_FILE_SB_BYPASS_EN is defined.
REQ-027 SHALL, with REG_FILE_SB_BYPASS_EN defined, return wdata on any read port whose raddr equals waddr (non-zero) while wen=1, and drive its rbusy=0 unless alloc_en=1 to the same index in that cycle.
REQ-028 SHALL, without REG_FILE_SB_BYPASS_EN, return the stored value and stored pending bit in that cycle; the new value is visible from the next cycle.

Verification
REQ-029 SHALL verify reset: write 0xDEADBEEF to r5, alloc r6, assert rst one cycle -> rdata(r5)=0, rbusy(r6)=0, busy_cnt=0.
REQ-030 SHALL verify r0: wen=1, waddr=0, wdata=0x12345678, alloc r0 -> read r0 = 0, rbusy=0, busy_cnt unchanged.
REQ-031 SHALL verify scoreboard: alloc r3, then r7 -> busy_cnt=2; write r3=0xA5 -> rbusy(r3)=0, busy_cnt=1, rdata(r3)=0xA5.
REQ-032 SHALL verify collision: r9 pending, same cycle wen r9=0x55 and alloc r9 -> next cycle r9=0x55, rbusy=1, busy_cnt unchanged.
REQ-033 SHALL verify bypass: r4=0x11, read r4 on port 0 and 1 while writing r4=0x22 -> 0x22 on both with macro, 0x11 without; 0x22 next cycle either way.
REQ-034 SHALL verify saturation: alloc r1..r31 in 31 cycles -> busy_cnt=31; re-alloc r31 -> busy_cnt stays 31.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with a per-register pending (scoreboard) bit.
// r0 is hardwired to zero and can never become pending.
// busy_cnt tracks how many registers are currently pending.
// Optional macro REG_FILE_SB_BYPASS_EN: a same-cycle write is forwarded
// to any read port that addresses the register being written.
module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NREAD      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wen,
    input  logic [ADDR_WIDTH-1:0]       waddr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic                        alloc_en,
    input  logic [ADDR_WIDTH-1:0]       alloc_addr,
    input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
    output logic [NREAD*DATA_WIDTH-1:0] rdata,
    output logic [NREAD-1:0]            rbusy,
    output logic [ADDR_WIDTH:0]         busy_cnt
);
    localparam int NREG = 1 << ADDR_WIDTH;
    localparam int CW   = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] regs_q [NREG];
    logic [DATA_WIDTH-1:0] regs_d [NREG];
    logic [NREG-1:0]       pend_q, pend_d;
    logic [CW-1:0]         busy_cnt_q, busy_cnt_d;

    logic wr_v, al_v, cnt_inc, cnt_dec;

    // Writes and allocations aimed at r0 are dropped here, so r0 stays zero and clear.
    assign wr_v = wen && (waddr != '0);
    assign al_v = alloc_en && (alloc_addr != '0);

    // Next-state: write clears the pending bit, allocation sets it and wins a same-index collision.
    always_comb begin
        regs_d     = regs_q;
        pend_d     = pend_q;
        if (wr_v) begin
            regs_d[waddr] = wdata;
            pend_d[waddr] = 1'b0;
        end
        if (al_v)
            pend_d[alloc_addr] = 1'b1;
        // Count only real bit transitions; a collision on a pending reg leaves it set.
        cnt_inc    = al_v && !pend_q[alloc_addr];
        cnt_dec    = wr_v && pend_q[waddr] && !(al_v && (alloc_addr == waddr));
        busy_cnt_d = busy_cnt_q + CW'(cnt_inc) - CW'(cnt_dec);
    end

    // State registers with synchronous reset overriding write and alloc.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
            pend_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            pend_q     <= pend_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd;
        logic                  rb;

        assign ra = raddr[p*ADDR_WIDTH +: ADDR_WIDTH];

        // Combinational read of data and pending bit, optionally forwarding the in-flight write.
        always_comb begin
            rd = regs_q[ra];
            rb = pend_q[ra];
`ifdef REG_FILE_SB_BYPASS_EN
            if (wr_v && (ra == waddr)) begin
                rd = wdata;
                rb = al_v && (alloc_addr == waddr);
            end
`else
`endif
        end

        assign rdata[p*DATA_WIDTH +: DATA_WIDTH] = rd;
        assign rbusy[p]                          = rb;
    end

endmodule
